// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data port of the unified word memory between
// requester A (CPU load/store) and requester B (loader/debug). Each request is a
// single read, dual read or write, sequenced IDLE -> ISSUE -> CAPTURE, with the
// done pulse one cycle after CAPTURE.
module mem_port_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2097152
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          a_req,
    input  logic [1:0]    a_op,
    input  logic [AW-1:0] a_addr1,
    input  logic [AW-1:0] a_addr2,
    input  logic [DW-1:0] a_wdata,
    output logic          a_done,
    output logic          a_err,
    output logic [DW-1:0] a_rdata1,
    output logic [DW-1:0] a_rdata2,

    input  logic          b_req,
    input  logic [1:0]    b_op,
    input  logic [AW-1:0] b_addr1,
    input  logic [AW-1:0] b_addr2,
    input  logic [DW-1:0] b_wdata,
    output logic          b_done,
    output logic          b_err,
    output logic [DW-1:0] b_rdata1,
    output logic [DW-1:0] b_rdata2,

    output logic          mem_en,
    output logic [1:0]    mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr1,
    output logic [AW-1:0] mem_addr2,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_data1,
    input  logic [DW-1:0] mem_data2
);

    // Upper half of the memory is not part of the data region.
    localparam logic [AW-1:0] DataLimit = AW'(DEPTH / 2);

    localparam logic [1:0] OpRead1 = 2'b00;
    localparam logic [1:0] OpRead2 = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

    state_e state_q, state_d;

    // Latched command of the current winner.
    logic [1:0]    cmd_op_q;
    logic [AW-1:0] cmd_addr1_q;
    logic [AW-1:0] cmd_addr2_q;
    logic [DW-1:0] cmd_wdata_q;
    logic          cmd_err_q;
    logic          cmd_b_q;     // 1: transaction belongs to B
    logic          last_b_q;    // 1: last grant went to B

    logic          a_done_q, a_err_q, b_done_q, b_err_q;
    logic [DW-1:0] a_rdata1_q, a_rdata2_q, b_rdata1_q, b_rdata2_q;

    logic          a_elig, b_elig, grant, grant_b;
    logic [1:0]    sel_op;
    logic [AW-1:0] sel_addr1, sel_addr2;
    logic [DW-1:0] sel_wdata;
    logic          sel_err;
    logic          cap_upd1, cap_upd2;
    logic [DW-1:0] cap_rd1, cap_rd2;

    // Round-robin arbitration and grant-time error decode.
    always_comb begin
        // A requester whose done is showing is masked for this cycle.
        a_elig    = a_req && !a_done_q;
        b_elig    = b_req && !b_done_q;
        grant     = (state_q == StIdle) && (a_elig || b_elig);
        grant_b   = b_elig && (!a_elig || !last_b_q);
        sel_op    = grant_b ? b_op    : a_op;
        sel_addr1 = grant_b ? b_addr1 : a_addr1;
        sel_addr2 = grant_b ? b_addr2 : a_addr2;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        sel_err   = (sel_op == OpIllegal) || (sel_addr1 >= DataLimit) ||
                    ((sel_op == OpRead2) && (sel_addr2 >= DataLimit));
    end

    // Which read-data words the capture updates, and with what.
    always_comb begin
        cap_upd1 = cmd_err_q || (cmd_op_q == OpRead1) || (cmd_op_q == OpRead2);
        cap_upd2 = cmd_err_q || (cmd_op_q == OpRead2);
        cap_rd1  = cmd_err_q ? '0 : mem_data1;
        cap_rd2  = cmd_err_q ? '0 : mem_data2;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed three-cycle sequence per transaction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (grant) state_d = StIssue;
            StIssue:   state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Memory control outputs: only ISSUE of an error-free command touches memory.
    always_comb begin
        mem_en    = 1'b1;
        mem_read  = 2'd0;
        mem_write = 1'b0;
        mem_addr1 = cmd_addr1_q;
        mem_addr2 = cmd_addr2_q;
        mem_wdata = cmd_wdata_q;
        if ((state_q == StIssue) && !cmd_err_q) begin
            case (cmd_op_q)
                OpRead1: mem_read  = 2'd1;
                OpRead2: mem_read  = 2'd2;
                OpWrite: mem_write = 1'b1;
                default: ;
            endcase
        end
    end

    // Command latch, grant history and per-requester response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_op_q    <= OpRead1;
            cmd_addr1_q <= '0;
            cmd_addr2_q <= '0;
            cmd_wdata_q <= '0;
            cmd_err_q   <= 1'b0;
            cmd_b_q     <= 1'b0;
            last_b_q    <= 1'b1;
            a_done_q    <= 1'b0;
            a_err_q     <= 1'b0;
            b_done_q    <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata1_q  <= '0;
            a_rdata2_q  <= '0;
            b_rdata1_q  <= '0;
            b_rdata2_q  <= '0;
        end else begin
            a_done_q <= 1'b0;
            a_err_q  <= 1'b0;
            b_done_q <= 1'b0;
            b_err_q  <= 1'b0;
            if (grant) begin
                cmd_op_q    <= sel_op;
                cmd_addr1_q <= sel_addr1;
                cmd_addr2_q <= sel_addr2;
                cmd_wdata_q <= sel_wdata;
                cmd_err_q   <= sel_err;
                cmd_b_q     <= grant_b;
                last_b_q    <= grant_b;
            end
            if (state_q == StCapture) begin
                if (cmd_b_q) begin
                    b_done_q <= 1'b1;
                    b_err_q  <= cmd_err_q;
                    if (cap_upd1) b_rdata1_q <= cap_rd1;
                    if (cap_upd2) b_rdata2_q <= cap_rd2;
                end else begin
                    a_done_q <= 1'b1;
                    a_err_q  <= cmd_err_q;
                    if (cap_upd1) a_rdata1_q <= cap_rd1;
                    if (cap_upd2) a_rdata2_q <= cap_rd2;
                end
            end
        end
    end

    assign a_done   = a_done_q;
    assign a_err    = a_err_q;
    assign a_rdata1 = a_rdata1_q;
    assign a_rdata2 = a_rdata2_q;
    assign b_done   = b_done_q;
    assign b_err    = b_err_q;
    assign b_rdata1 = b_rdata1_q;
    assign b_rdata2 = b_rdata2_q;

endmodule
